// File: rtl/cpu_pkg.sv
// Shared CPU-level types and default sizing for the return-address stack.
package cpu_pkg;

    parameter int RAS_ADDR_W = 12;
    parameter int RAS_DEPTH  = 8;

    typedef logic [RAS_ADDR_W-1:0] ret_addr_t;

endpackage

// File: rtl/return_addr_stack.sv
// Parametrised return-address stack with zero-latency pop, flush and sticky error flags.
// Optional build macro RAS_WRAP_EN: a push while full overwrites the oldest entry.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          address_in,
    output logic [ADDR_W-1:0]          address_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("return_addr_stack: DEPTH must be a power of two >= 2");
    end

`ifdef RAS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic              wr_en;
    logic              replace;

    assign top_idx = ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign replace = push && pop && !empty;

    assign address_out = (pop && !empty) ? mem[top_idx] : '0;

    // Push+pop on a non-empty stack rewrites the current top in place.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr;
        if (!flush) begin
            if (replace) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (push && (!full || WRAP)) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= address_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (replace) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            if (!full) begin
                ptr   <= ptr + PTR_W'(1);
                count <= count + CNT_W'(1);
            end else if (WRAP) begin
                ptr <= ptr + PTR_W'(1);
            end else begin
                overflow <= 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                ptr   <= top_idx;
                count <= count - CNT_W'(1);
            end else begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
